// File: rtl/adder_16bit_accum.sv
// adder_16bit_accum
//
// Accumulates the 17-bit results of a 16-bit adder ({in_co, in_sum}) into a wide
// accumulator. One result is taken per valid/ready beat. A burst closes after
// BURST_LEN beats, or earlier when flush is raised after at least one beat. The
// closed burst is then offered on a valid/ready output as a total, a beat count and
// a sticky overflow flag. While that output waits, the input stalls.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   adder result valid
//   in_ready   a result can be accepted this cycle
//   in_sum     adder y
//   in_co      adder carry-out
//   flush      close the current burst early
//   out_valid  burst total available
//   out_ready  sink accepts the total
//   out_acc    accumulated total; saturates at all-ones
//   out_cnt    number of beats in the burst
//   out_ovf    the accumulator overflowed at some point during the burst
module adder_16bit_accum #(
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_sum,
    input  logic             in_co,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    localparam logic [CNT_W-1:0] BurstLenC = CNT_W'(BURST_LEN);
    localparam logic [ACC_W-1:0] AccMax    = '1;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_ovf_q, out_ovf_d;

    logic             beat;
    logic             close;
    logic [ACC_W-1:0] val;
    logic [ACC_W:0]   sum_wide;
    logic [CNT_W-1:0] cnt_inc;

    // Reset overrides everything, including the input handshake.
    assign in_ready = ~rst & (state_q != StDone);
    assign beat     = in_valid & in_ready;
    assign val      = ACC_W'({in_co, in_sum});
    // One extra bit so the carry-out of the accumulator is visible.
    assign sum_wide = {1'b0, acc_q} + {1'b0, val};
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        close   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A flush on its own is ignored here, so empty bursts never appear.
                if (beat) begin
                    acc_d   = val;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = StAccum;
                    close   = (BURST_LEN == 1) || flush;
                end
            end
            StAccum: begin
                if (beat) begin
                    cnt_d = cnt_inc;
                    // Once saturated, acc stays pinned at all-ones until the burst ends.
                    if (sum_wide[ACC_W] || ovf_q) begin
                        acc_d = AccMax;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_wide[ACC_W-1:0];
                    end
                    close = (cnt_inc == BurstLenC) || flush;
                end else if (flush) begin
                    close = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (close) begin
            state_d = StDone;
        end
    end

    // Output registers load only when a burst closes, so they keep the last total
    // through IDLE/ACCUM and stay stable while DONE waits for the sink.
    always_comb begin
        out_acc_d = out_acc_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;
        if (close) begin
            out_acc_d = acc_d;
            out_cnt_d = cnt_d;
            out_ovf_d = ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_acc_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_acc_q <= out_acc_d;
            out_cnt_q <= out_cnt_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign out_acc   = out_acc_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_16bit_accum.sv
// Testbench for adder_16bit_accum. Runs the DUT with a 4-beat burst and an 18-bit
// accumulator, so saturation is reachable within one burst. An input-side model
// gathers the accepted values of each burst and, when the burst closes, pushes the
// expected total into a queue. An output monitor pops from that queue and compares
// on each output handshake.
module tb_adder_16bit_accum;

    localparam int unsigned BL      = 4;
    localparam int unsigned AW      = 18;
    localparam int unsigned CW      = $clog2(BL + 1);
    localparam longint      ACC_MAX = (64'sd1 <<< AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_sum;
    logic          in_co;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic [CW-1:0] out_cnt;
    logic          out_ovf;

    adder_16bit_accum #(
        .BURST_LEN(BL),
        .ACC_W    (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sum   (in_sum),
        .in_co    (in_co),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_cnt  (out_cnt),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint acc;
        longint cnt;
        bit     ovf;
    } res_t;

    int     errors = 0;
    int     checks = 0;
    res_t   exp_q[$];
    longint burst_q[$];
    bit     pending = 1'b0;
    bit     chk_en  = 1'b0;
    bit     rand_rdy = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The reference total is the plain sum of the burst, clamped. The values are
    // non-negative, so the running sum crosses the limit exactly when the final sum does.
    task automatic close_burst();
        longint total = 0;
        res_t   r;
        foreach (burst_q[i]) total += burst_q[i];
        r.ovf = (total > ACC_MAX);
        r.acc = r.ovf ? ACC_MAX : total;
        r.cnt = burst_q.size();
        exp_q.push_back(r);
        burst_q.delete();
        pending = 1'b1;
    endtask

    // Input-side model: decides what the coming rising edge does.
    always @(negedge clk) begin
        longint v;
        if (chk_en) begin
            check("in_ready", longint'(in_ready), longint'(!rst && !pending));
            check("out_valid", longint'(out_valid), longint'(pending));
        end
        if (rst) begin
            burst_q.delete();
            exp_q.delete();
            pending = 1'b0;
        end else if (pending) begin
            if (out_ready) pending = 1'b0;
        end else if (in_valid) begin
            v = longint'({in_co, in_sum});
            burst_q.push_back(v);
            if (burst_q.size() == BL || flush) close_burst();
        end else if (flush && burst_q.size() > 0) begin
            close_burst();
        end
    end

    // Output monitor: checks the offered total each cycle and retires it on handshake.
    always @(negedge clk) begin
        if (chk_en && !rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("out_valid_unexpected", 1, 0);
            end else begin
                check("out_acc", longint'(out_acc), exp_q[0].acc);
                check("out_cnt", longint'(out_cnt), exp_q[0].cnt);
                check("out_ovf", longint'(out_ovf), longint'(exp_q[0].ovf));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [16:0] v, input bit fl);
        int waitc = 0;
        in_valid = 1'b1;
        {in_co, in_sum} = v;
        flush = fl;
        @(negedge clk);
        while (!in_ready && waitc < 100) begin
            waitc++;
            @(negedge clk);
        end
        if (!in_ready) check("beat_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        {in_co, in_sum} = 17'($urandom);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    task automatic drain();
        int waitc = 0;
        while ((pending || exp_q.size() != 0) && waitc < 200) begin
            waitc++;
            @(negedge clk);
        end
        if (pending || exp_q.size() != 0) check("drain_timeout", 0, 1);
        idle(1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_sum = '0;
        in_co = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        idle(2);
        rst = 1'b0;

        // Reset state as seen after release.
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_acc", longint'(out_acc), 0);
        check("rst_out_cnt", longint'(out_cnt), 0);
        check("rst_out_ovf", longint'(out_ovf), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        chk_en = 1'b1;
        idle(1);
        out_ready = 1'b1;

        // Plain full burst: 1+2+3+4.
        send_beat(17'h00001, 1'b0);
        send_beat(17'h00002, 1'b0);
        send_beat(17'h00003, 1'b0);
        send_beat(17'h00004, 1'b0);
        drain();

        // Saturating burst, then a small burst to show the flag is per burst.
        repeat (4) send_beat(17'h1FFFF, 1'b0);
        drain();
        repeat (4) send_beat(17'h00001, 1'b0);
        drain();

        // Flush with a beat closes early and includes that beat.
        send_beat(17'd4, 1'b0);
        send_beat(17'd5, 1'b0);
        send_beat(17'd6, 1'b1);
        drain();
        // Flush alone in IDLE produces nothing.
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(3);

        // Sink stalls in DONE while a new result is offered.
        out_ready = 1'b0;
        send_beat(17'd10, 1'b0);
        send_beat(17'd20, 1'b0);
        send_beat(17'd30, 1'b0);
        send_beat(17'd40, 1'b0);
        fork
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b1;
            end
        join_none
        send_beat(17'd7, 1'b0);
        send_beat(17'd8, 1'b0);
        send_beat(17'd9, 1'b0);
        send_beat(17'h10000, 1'b0);
        drain();

        // Reset mid-burst discards the partial sum.
        send_beat(17'd100, 1'b0);
        send_beat(17'd200, 1'b0);
        do_reset(2);
        repeat (4) send_beat(17'd1, 1'b0);
        drain();

        // Reset in DONE discards the pending total.
        out_ready = 1'b0;
        repeat (4) send_beat(17'd50, 1'b0);
        idle(2);
        do_reset(1);
        out_ready = 1'b1;
        repeat (4) send_beat(17'd5, 1'b0);
        drain();

        // Randomized traffic with random sink back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [16:0] v;
            idle(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 0) v = 17'($urandom);
            else v = 17'($urandom_range(0, 255));
            send_beat(v, ($urandom_range(0, 5) == 0));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
